// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM encoder/decoder pair: FSM state codes and
// default window and synchroniser sizes.
package pdm_pkg;

    localparam int DEF_WINDOW_LOG2 = 5;
    localparam int DEF_SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/pdm_sync.sv
// Multi-flop synchroniser bringing the asynchronous PDM bitstream into the
// clk domain; all flops clear on reset.
module pdm_sync
    import pdm_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pdm_decoder.sv
// PDM decoder: counts ones over fixed windows of 2^WINDOW_LOG2 clocks and
// reports the saturated density, discarding the first (priming) window.
module pdm_decoder
    import pdm_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   pdm_in,
    output logic [WINDOW_LOG2-1:0] level,
    output logic                   level_valid,
    output logic                   stable
);

    localparam logic [WINDOW_LOG2-1:0] WCNT_LAST = '1;

    logic                   pdm_s;
    logic [1:0]             state;
    logic [WINDOW_LOG2-1:0] wcnt;
    logic [WINDOW_LOG2:0]   acc;
    logic [WINDOW_LOG2:0]   result;
    logic [WINDOW_LOG2-1:0] result_sat;
    logic [WINDOW_LOG2-1:0] prev_level;
    logic                   have_prev;
    logic                   counting;
    logic                   win_end;
    logic                   run_end;

    // A full window of ones (result = N) does not fit the level code; clamp to N-1.
    function automatic logic [WINDOW_LOG2-1:0] sat_level(input logic [WINDOW_LOG2:0] r);
        return r[WINDOW_LOG2] ? {WINDOW_LOG2{1'b1}} : r[WINDOW_LOG2-1:0];
    endfunction

    pdm_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pdm_in),
        .q     (pdm_s)
    );

    assign counting   = (state == ST_PRIME) || (state == ST_RUN);
    assign win_end    = counting && (wcnt == WCNT_LAST);
    assign run_end    = (state == ST_RUN) && win_end;
    assign result     = acc + {{WINDOW_LOG2{1'b0}}, pdm_s};
    assign result_sat = sat_level(result);

    // Control: FSM, window counter and ones accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wcnt      <= '0;
            acc       <= '0;
            have_prev <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wcnt      <= '0;
                    acc       <= '0;
                    have_prev <= 1'b0;
                    if (en) begin
                        state <= ST_PRIME;
                    end
                end
                ST_PRIME, ST_RUN: begin
                    wcnt <= wcnt + 1'b1;
                    acc  <= win_end ? '0 : result;
                    if (win_end && (state == ST_PRIME)) begin
                        state <= ST_RUN;
                    end
                    if (run_end) begin
                        have_prev <= 1'b1;
                    end
                    // Dropping en abandons a partial window; a completing window still reports below.
                    if (!en) begin
                        state <= ST_IDLE;
                        wcnt  <= '0;
                        acc   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    wcnt  <= '0;
                    acc   <= '0;
                end
            endcase
        end
    end

    // Output: level register, valid pulse and stability flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level       <= '0;
            level_valid <= 1'b0;
            stable      <= 1'b0;
            prev_level  <= '0;
        end else begin
            level_valid <= 1'b0;
            if (run_end) begin
                level       <= result_sat;
                level_valid <= 1'b1;
                stable      <= have_prev && (result_sat == prev_level);
                prev_level  <= result_sat;
            end else if (!counting || !en) begin
                stable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_decoder.sv
// Scoreboard bench for pdm_decoder using window-periodic PDM patterns whose
// per-window ones count is independent of window phase.
module tb_pdm_decoder;

    localparam int WL = 5;

    localparam logic [31:0] P_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] P_ZERO = 32'h0000_0000;
    localparam logic [31:0] P_8    = 32'h1111_1111;
    localparam logic [31:0] P_16   = 32'h0000_FFFF;
    localparam logic [31:0] P_26   = 32'h03FF_FFFF;

    typedef struct {
        int cyc;
        int lo;
        int hi;
        int stb;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          pdm_in;
    logic [WL-1:0] level;
    logic          level_valid;
    logic          stable;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] pat;
    exp_t        sb[$];
    exp_t        mon_e;

    pdm_decoder #(
        .WINDOW_LOG2 (WL),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pdm_in      (pdm_in),
        .level       (level),
        .level_valid (level_valid),
        .stable      (stable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        pdm_in = pat[cyc[4:0]];
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic push(input int c, input int lo, input int hi, input int stb);
        exp_t e;
        e.cyc = c;
        e.lo  = lo;
        e.hi  = hi;
        e.stb = stb;
        sb.push_back(e);
    endtask

    task automatic start(input logic [31:0] p, output int c);
        tick();
        pat    = p;
        pdm_in = p[cyc[4:0]];
        en     = 1'b1;
        c      = cyc;
    endtask

    task automatic stop_idle(input int n);
        en = 1'b0;
        repeat (n) tick();
        check("idle_stable", stable, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1 && level_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", level_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("valid_cycle", cyc, mon_e.cyc);
                if (mon_e.lo == mon_e.hi) check("level", level, mon_e.lo);
                else check("level_range", (level >= mon_e.lo && level <= mon_e.hi), 1);
                if (mon_e.stb >= 0) check("stable", stable, mon_e.stb);
            end
        end
    end

    initial begin
        int c0;
        int c1;
        reset  = 1'b1;
        en     = 1'b0;
        pdm_in = 1'b0;
        pat    = P_ZERO;
        repeat (3) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_valid", level_valid, 0);
        check("rst_stable", stable, 0);
        reset = 1'b0;

        // All ones: saturates to 31, stable from the second window.
        start(P_ONES, c0);
        push(c0 + 65, 31, 31, 0);
        push(c0 + 97, 31, 31, 1);
        push(c0 + 129, 31, 31, 1);
        wait_to(c0 + 139);
        stop_idle(20);

        // All zeros.
        start(P_ZERO, c0);
        push(c0 + 65, 0, 0, 0);
        push(c0 + 97, 0, 0, 1);
        push(c0 + 129, 0, 0, 1);
        wait_to(c0 + 139);
        stop_idle(20);

        // Density 8 switching to 26 with en held; the straddling window is tolerant.
        start(P_8, c0);
        push(c0 + 65, 8, 8, 0);
        push(c0 + 97, 8, 8, 1);
        push(c0 + 129, 8, 8, 1);
        push(c0 + 161, 7, 27, -1);
        push(c0 + 193, 26, 26, -1);
        push(c0 + 225, 26, 26, 1);
        wait_to(c0 + 134);
        pat = P_26;
        wait_to(c0 + 235);
        stop_idle(20);

        // en low for 3 clocks at wcnt=10: level held, full restart.
        start(P_8, c0);
        push(c0 + 65, 8, 8, 0);
        wait_to(c0 + 75);
        en = 1'b0;
        tick();
        tick();
        check("gap_level_hold", level, 8);
        check("gap_stable", stable, 0);
        tick();
        en = 1'b1;
        c1 = cyc;
        push(c1 + 65, 8, 8, 0);
        push(c1 + 97, 8, 8, 1);
        wait_to(c1 + 107);
        stop_idle(20);

        // en falls on a window-end clock: that window still reports.
        start(P_16, c0);
        push(c0 + 65, 16, 16, 0);
        push(c0 + 97, 16, 16, 1);
        wait_to(c0 + 96);
        en = 1'b0;
        tick();
        tick();
        check("drop_valid_low", level_valid, 0);
        check("drop_stable", stable, 0);
        check("drop_level_hold", level, 16);
        repeat (80) tick();
        check("drop_sb_drained", sb.size(), 0);

        // Asynchronous reset between edges during RUN, then resumed decode.
        start(P_ONES, c0);
        push(c0 + 65, 31, 31, 0);
        wait_to(c0 + 70);
        #2 reset = 1'b1;
        #1;
        check("arst_level", level, 0);
        check("arst_valid", level_valid, 0);
        check("arst_stable", stable, 0);
        tick();
        tick();
        reset = 1'b0;
        c1 = cyc;
        push(c1 + 65, 31, 31, 0);
        push(c1 + 97, 31, 31, 1);
        wait_to(c1 + 107);
        stop_idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
